// File: rtl/data_memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_responder_pkg
// Shared definitions for the data-memory responder slice: the CPU word width
// used by the pipeline stages, the latched operation type, the latency counter
// width and the helper that computes the counter preload.
// -----------------------------------------------------------------------------
package data_memory_responder_pkg;

    // Word width shared with the CPU pipeline stages (data and address).
    localparam int CPU_WORD_SIZE = 16;

    // Latency counter width; LATENCY is limited to 1..15.
    localparam int CNT_BITS = 4;

    // Operation captured at the request sample.
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Counter preload for a given access latency (LATENCY-1).
    function automatic logic [CNT_BITS-1:0] latency_preload(input int unsigned lat);
        logic [31:0] lat_m1;
        lat_m1 = lat - 32'd1;
        return lat_m1[CNT_BITS-1:0];
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// -----------------------------------------------------------------------------
// data_memory_if
// Request/handshake signals between the MEM stage (master) and the data-memory
// responder (slave).
//   d_readM   : read request, held until d_ready is sampled high
//   d_writeM  : write request, held until d_ready is sampled high
//   d_address : word address, held with the request
//   d_ready   : one-cycle access-complete pulse from the responder
// The bidirectional d_data bus is kept out of the interface and carried as a
// plain inout net so the tri-state resolution happens on a single top-level
// wire shared by the requester and the responder.
// -----------------------------------------------------------------------------
interface data_memory_if
    import data_memory_responder_pkg::*;
#(
    parameter int WORD_SIZE = CPU_WORD_SIZE
) ();

    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic                 d_ready;

    modport master (
        output d_readM,
        output d_writeM,
        output d_address,
        input  d_ready
    );

    modport slave (
        input  d_readM,
        input  d_writeM,
        input  d_address,
        output d_ready
    );

endinterface

// File: rtl/data_memory_responder_array.sv
// -----------------------------------------------------------------------------
// data_memory_array
// Word storage for the responder: synchronous write, asynchronous read.
// Contents are deliberately not reset so they survive a responder reset.
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module data_memory_array
    import data_memory_responder_pkg::*;
#(
    parameter int WORD_SIZE = CPU_WORD_SIZE,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WORD_SIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WORD_SIZE-1:0] mem_r [DEPTH];

    // Storage write port; no reset so contents persist across responder resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Memory-side responder for the CPU data-memory port. In IDLE it samples a
// request (write wins over read), waits a fixed LATENCY, commits a write or
// drives read data on d_data for exactly one DONE cycle, and pulses d_ready
// during that same cycle.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (memory contents kept)
//   bus      : data_memory_if slave (d_readM, d_writeM, d_address, d_ready)
//   d_data   : shared data bus; sampled on write, driven only in a read DONE
// Parameters: WORD_SIZE (data/address width), ADDR_BITS (index width,
// depth 2^ADDR_BITS), LATENCY (1..15 cycles from sample to d_ready).
// -----------------------------------------------------------------------------
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int WORD_SIZE = CPU_WORD_SIZE,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    data_memory_if.slave         bus,
    inout  wire  [WORD_SIZE-1:0] d_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [CNT_BITS-1:0] CNT_LOAD = latency_preload(LATENCY);

    state_e                 state_r;
    state_e                 state_s;
    logic [CNT_BITS-1:0]    cnt_r;
    logic [CNT_BITS-1:0]    cnt_s;
    op_e                    op_r;
    op_e                    op_s;
    logic [ADDR_BITS-1:0]   idx_r;
    logic [ADDR_BITS-1:0]   idx_s;
    logic [WORD_SIZE-1:0]   wdata_r;
    logic [WORD_SIZE-1:0]   wdata_s;

    logic                   ready_r;
    logic                   oe_r;
    logic [WORD_SIZE-1:0]   rdata_r;

    logic                   enter_done_s;
    logic                   mem_we_s;
    logic                   rd_load_s;
    logic [WORD_SIZE-1:0]   mem_rdata_s;
    logic                   unused_addr_hi_s;

    // Upper address bits alias modulo depth; fold them so they stay visibly consumed.
    assign unused_addr_hi_s = ^bus.d_address[WORD_SIZE-1:ADDR_BITS];

    // Next-state logic: request sampling in IDLE, latency countdown in BUSY.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        idx_s   = idx_r;
        wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.d_writeM) begin
                    // Write has priority when both request lines are high.
                    op_s    = OP_WRITE;
                    idx_s   = bus.d_address[ADDR_BITS-1:0];
                    wdata_s = d_data;
                    cnt_s   = CNT_LOAD;
                    state_s = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end else if (bus.d_readM) begin
                    op_s    = OP_READ;
                    idx_s   = bus.d_address[ADDR_BITS-1:0];
                    cnt_s   = CNT_LOAD;
                    state_s = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_s = cnt_r - {{(CNT_BITS-1){1'b0}}, 1'b1};
                if (cnt_r <= {{(CNT_BITS-1){1'b0}}, 1'b1}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                // DONE never samples; the requester is still holding its request.
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Commit/capture strobes for the edge that enters DONE. The next-values are
    // used so a LATENCY=1 access, which latches and completes on one edge, works.
    always_comb begin
        enter_done_s = (state_s == ST_DONE);
        if (enter_done_s && reset_n) begin
            mem_we_s  = (op_s == OP_WRITE);
            rd_load_s = (op_s == OP_READ);
        end else begin
            mem_we_s  = 1'b0;
            rd_load_s = 1'b0;
        end
    end

    // FSM, counter and request latches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_BITS{1'b0}};
            op_r    <= OP_READ;
            idx_r   <= {ADDR_BITS{1'b0}};
            wdata_r <= {WORD_SIZE{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            idx_r   <= idx_s;
            wdata_r <= wdata_s;
        end
    end

    // Registered handshake, output enable and read data for the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r <= 1'b0;
            oe_r    <= 1'b0;
            rdata_r <= {WORD_SIZE{1'b0}};
        end else begin
            ready_r <= enter_done_s;
            oe_r    <= rd_load_s;
            if (rd_load_s) begin
                rdata_r <= mem_rdata_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    data_memory_array #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (idx_s),
        .wdata (wdata_s),
        .raddr (idx_s),
        .rdata (mem_rdata_s)
    );

    assign bus.d_ready = ready_r;
    assign d_data      = oe_r ? rdata_r : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Directed bench with three responders (LATENCY 2, 1 and 4). The bench acts as
// the MEM stage: it holds each request until it has sampled d_ready high, then
// presents the next one. Outside the one cycle in which read data is expected,
// the bench keeps its own driver on d_data (write data, or 0000 as a probe);
// seeing anything other than its own value there means the responder drove
// the bus when it should have been released.
// Inputs change on the falling edge; outputs are observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;
    import data_memory_responder_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rst_n;
    logic [2:0]   tb_oe;
    logic [W-1:0] tb_val [3];

    int vectors     = 0;
    int miscompares = 0;

    data_memory_if #(.WORD_SIZE(W)) bus_l2 ();
    data_memory_if #(.WORD_SIZE(W)) bus_l1 ();
    data_memory_if #(.WORD_SIZE(W)) bus_l4 ();

    wire [W-1:0] d_data_l2;
    wire [W-1:0] d_data_l1;
    wire [W-1:0] d_data_l4;

    assign d_data_l2 = tb_oe[0] ? tb_val[0] : {W{1'bz}};
    assign d_data_l1 = tb_oe[1] ? tb_val[1] : {W{1'bz}};
    assign d_data_l4 = tb_oe[2] ? tb_val[2] : {W{1'bz}};

    data_memory_responder #(.WORD_SIZE(W), .ADDR_BITS(8), .LATENCY(2)) u_dut_l2 (
        .clk (clk), .reset_n (rst_n[0]), .bus (bus_l2.slave), .d_data (d_data_l2));
    data_memory_responder #(.WORD_SIZE(W), .ADDR_BITS(8), .LATENCY(1)) u_dut_l1 (
        .clk (clk), .reset_n (rst_n[1]), .bus (bus_l1.slave), .d_data (d_data_l1));
    data_memory_responder #(.WORD_SIZE(W), .ADDR_BITS(8), .LATENCY(4)) u_dut_l4 (
        .clk (clk), .reset_n (rst_n[2]), .bus (bus_l4.slave), .d_data (d_data_l4));

    // Drive request lines and the bench side of d_data for one responder.
    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [W-1:0] addr, input logic [W-1:0] val, input logic oe);
        tb_val[sel] = val;
        tb_oe[sel]  = oe;
        case (sel)
            0:       begin bus_l2.d_readM = rd; bus_l2.d_writeM = wr; bus_l2.d_address = addr; end
            1:       begin bus_l1.d_readM = rd; bus_l1.d_writeM = wr; bus_l1.d_address = addr; end
            default: begin bus_l4.d_readM = rd; bus_l4.d_writeM = wr; bus_l4.d_address = addr; end
        endcase
    endtask

    // Observe d_ready and the resolved bus right now.
    task automatic peek(input int sel, output logic rdy, output logic [W-1:0] data);
        case (sel)
            0:       begin rdy = bus_l2.d_ready; data = d_data_l2; end
            1:       begin rdy = bus_l1.d_ready; data = d_data_l1; end
            default: begin rdy = bus_l4.d_ready; data = d_data_l4; end
        endcase
    endtask

    // One clock: cross the rising edge, observe at the following falling edge.
    task automatic tick(input int sel, output logic rdy, output logic [W-1:0] data);
        @(posedge clk);
        @(negedge clk);
        peek(sel, rdy, data);
    endtask

    // Run one held-request access of lat+1 cycles and record what was seen.
    // rdy_trace[k] / drv_trace[k] describe observation k (k=1 is just after the
    // sampling edge). The bench releases d_data only for observation lat of a
    // pure read, where done_data is captured. drop_tick>0 lowers the request
    // before that observation. Ends with the requester idle.
    task automatic access(input int sel, input int lat, input logic rd, input logic wr,
                          input logic [W-1:0] addr, input logic [W-1:0] wdata, input int drop_tick,
                          output logic [15:0] rdy_trace, output logic [15:0] drv_trace,
                          output logic [W-1:0] done_data);
        logic         r;
        logic [W-1:0] d;
        logic         cur_rd;
        logic         cur_wr;
        logic         rd_only;
        logic [W-1:0] pv;
        cur_rd    = rd;
        cur_wr    = wr;
        rd_only   = rd & ~wr;
        pv        = wr ? wdata : 16'h0000;
        rdy_trace = 16'h0000;
        drv_trace = 16'h0000;
        done_data = 16'h0000;
        for (int k = 1; k <= lat + 1; k++) begin
            if (k == drop_tick) begin
                cur_rd = 1'b0;
                cur_wr = 1'b0;
            end
            drive(sel, cur_rd, cur_wr, addr, pv, !(rd_only && k == lat));
            tick(sel, r, d);
            rdy_trace[k] = r;
            if (rd_only && k == lat) begin
                done_data = d;
            end else if (d !== pv) begin
                drv_trace[k] = 1'b1;
            end
        end
        drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    endtask

    task automatic test_reset();
        logic         r;
        logic [W-1:0] d;
        for (int s = 0; s < 3; s++) begin
            peek(s, r, d);
            vectors++;
            if (r !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ready[%0d]: got %b want 0", s, r);
            end
            vectors++;
            if (d !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_bus[%0d]: got %h want 0000 (bench probe only)", s, d);
            end
        end
    endtask

    // LATENCY=2: d_ready is high in observation 2, i.e. sampled by MEM on the
    // second edge after the sampling edge.
    task automatic test_write_read();
        logic [15:0]  rt;
        logic [15:0]  dt;
        logic [W-1:0] dd;
        access(0, 2, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, rt, dt, dd);
        vectors++;
        if (rt !== 16'h0004) begin miscompares++; $display("FAIL wr_ready_trace: got %b want %b", rt, 16'h0004); end
        vectors++;
        if (dt !== 16'h0000) begin miscompares++; $display("FAIL wr_bus_released: got %b want %b", dt, 16'h0000); end
        access(0, 2, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, rt, dt, dd);
        vectors++;
        if (rt !== 16'h0004) begin miscompares++; $display("FAIL rd_ready_trace: got %b want %b", rt, 16'h0004); end
        vectors++;
        if (dd !== 16'hBEEF) begin miscompares++; $display("FAIL rd_data: got %h want BEEF", dd); end
        vectors++;
        if (dt !== 16'h0000) begin miscompares++; $display("FAIL rd_bus_released: got %b want %b", dt, 16'h0000); end
    endtask

    // LATENCY=1: two-cycle accesses presented with no gap.
    task automatic test_back_to_back();
        logic [15:0]  rt;
        logic [15:0]  dt;
        logic [W-1:0] dd;
        access(1, 1, 1'b0, 1'b1, 16'h0003, 16'h1234, 0, rt, dt, dd);
        vectors++;
        if (rt !== 16'h0002) begin miscompares++; $display("FAIL b2b_wr_ready: got %b want %b", rt, 16'h0002); end
        vectors++;
        if (dt !== 16'h0000) begin miscompares++; $display("FAIL b2b_wr_bus: got %b want %b", dt, 16'h0000); end
        access(1, 1, 1'b1, 1'b0, 16'h0003, 16'h0000, 0, rt, dt, dd);
        vectors++;
        if (rt !== 16'h0002) begin miscompares++; $display("FAIL b2b_rd_ready: got %b want %b", rt, 16'h0002); end
        vectors++;
        if (dd !== 16'h1234) begin miscompares++; $display("FAIL b2b_rd_data: got %h want 1234", dd); end
        access(1, 1, 1'b0, 1'b1, 16'h0004, 16'h4321, 0, rt, dt, dd);
        access(1, 1, 1'b1, 1'b0, 16'h0003, 16'h0000, 0, rt, dt, dd);
        vectors++;
        if (dd !== 16'h1234) begin miscompares++; $display("FAIL b2b_neighbour: got %h want 1234", dd); end
    endtask

    task automatic test_alias();
        logic [15:0]  rt;
        logic [15:0]  dt;
        logic [W-1:0] dd;
        access(0, 2, 1'b0, 1'b1, 16'h0105, 16'hAAAA, 0, rt, dt, dd);
        vectors++;
        if (rt !== 16'h0004) begin miscompares++; $display("FAIL alias_wr_ready: got %b want %b", rt, 16'h0004); end
        access(0, 2, 1'b1, 1'b0, 16'h0005, 16'h0000, 0, rt, dt, dd);
        vectors++;
        if (dd !== 16'hAAAA) begin miscompares++; $display("FAIL alias_rd_data: got %h want AAAA", dd); end
        vectors++;
        if (rt !== 16'h0004) begin miscompares++; $display("FAIL alias_rd_ready: got %b want %b", rt, 16'h0004); end
    endtask

    // Both request lines high: treated as a write, bus never driven back.
    task automatic test_simultaneous();
        logic [15:0]  rt;
        logic [15:0]  dt;
        logic [W-1:0] dd;
        access(0, 2, 1'b0, 1'b1, 16'h0020, 16'h0F0F, 0, rt, dt, dd);
        access(0, 2, 1'b1, 1'b1, 16'h0020, 16'h5555, 0, rt, dt, dd);
        vectors++;
        if (rt !== 16'h0004) begin miscompares++; $display("FAIL both_ready: got %b want %b", rt, 16'h0004); end
        vectors++;
        if (dt !== 16'h0000) begin miscompares++; $display("FAIL both_no_drive: got %b want %b", dt, 16'h0000); end
        access(0, 2, 1'b1, 1'b0, 16'h0020, 16'h0000, 0, rt, dt, dd);
        vectors++;
        if (dd !== 16'h5555) begin miscompares++; $display("FAIL both_readback: got %h want 5555", dd); end
    endtask

    // Read request lowered while BUSY still completes; nothing follows it.
    task automatic test_drop();
        logic [15:0]  rt;
        logic [15:0]  dt;
        logic [W-1:0] dd;
        logic         r;
        logic [W-1:0] d;
        int           extra_rdy;
        int           extra_drv;
        access(0, 2, 1'b1, 1'b0, 16'h0010, 16'h0000, 2, rt, dt, dd);
        vectors++;
        if (rt !== 16'h0004) begin miscompares++; $display("FAIL drop_ready: got %b want %b", rt, 16'h0004); end
        vectors++;
        if (dd !== 16'hBEEF) begin miscompares++; $display("FAIL drop_data: got %h want BEEF", dd); end
        vectors++;
        if (dt !== 16'h0000) begin miscompares++; $display("FAIL drop_bus: got %b want %b", dt, 16'h0000); end
        extra_rdy = 0;
        extra_drv = 0;
        for (int k = 0; k < 5; k++) begin
            tick(0, r, d);
            if (r !== 1'b0) extra_rdy++;
            if (d !== 16'h0000) extra_drv++;
        end
        vectors++;
        if (extra_rdy != 0) begin miscompares++; $display("FAIL drop_no_new_access: got %0d ready pulses want 0", extra_rdy); end
        vectors++;
        if (extra_drv != 0) begin miscompares++; $display("FAIL drop_idle_bus: got %0d driven cycles want 0", extra_drv); end
    endtask

    // LATENCY=4: reset in BUSY drops a write; reset in DONE releases at once.
    task automatic test_reset_mid_access();
        logic [15:0]  rt;
        logic [15:0]  dt;
        logic [W-1:0] dd;
        logic         r;
        logic [W-1:0] d;
        access(2, 4, 1'b0, 1'b1, 16'h0030, 16'h1111, 0, rt, dt, dd);
        vectors++;
        if (rt !== 16'h0010) begin miscompares++; $display("FAIL l4_ready_trace: got %b want %b", rt, 16'h0010); end
        drive(2, 1'b0, 1'b1, 16'h0030, 16'h7777, 1'b1);
        tick(2, r, d);
        tick(2, r, d);
        rst_n[2] = 1'b0;
        #1;
        peek(2, r, d);
        vectors++;
        if (r !== 1'b0) begin miscompares++; $display("FAIL busy_reset_ready: got %b want 0", r); end
        vectors++;
        if (d !== 16'h7777) begin miscompares++; $display("FAIL busy_reset_bus: got %h want 7777 (bench only)", d); end
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        #1;
        rst_n[2] = 1'b1;
        access(2, 4, 1'b1, 1'b0, 16'h0030, 16'h0000, 0, rt, dt, dd);
        vectors++;
        if (dd !== 16'h1111) begin miscompares++; $display("FAIL dropped_write_data: got %h want 1111", dd); end
        vectors++;
        if (rt !== 16'h0010) begin miscompares++; $display("FAIL post_reset_ready: got %b want %b", rt, 16'h0010); end
        drive(2, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1);
        tick(2, r, d);
        tick(2, r, d);
        tick(2, r, d);
        drive(2, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0);
        tick(2, r, d);
        vectors++;
        if ({r, d} !== {1'b1, 16'h1111}) begin miscompares++; $display("FAIL done_before_reset: got %b/%h want 1/1111", r, d); end
        drive(2, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        rst_n[2] = 1'b0;
        #1;
        peek(2, r, d);
        vectors++;
        if (r !== 1'b0) begin miscompares++; $display("FAIL done_reset_ready: got %b want 0", r); end
        vectors++;
        if (d !== 16'h0000) begin miscompares++; $display("FAIL done_reset_bus: got %h want 0000 (bench only)", d); end
        #1;
        rst_n[2] = 1'b1;
        tick(2, r, d);
        vectors++;
        if (r !== 1'b0) begin miscompares++; $display("FAIL after_reset_idle: got %b want 0", r); end
    endtask

    initial begin
        rst_n = 3'b000;
        tb_oe = 3'b111;
        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 3'b111;
        test_write_read();
        test_back_to_back();
        test_alias();
        test_simultaneous();
        test_drop();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
